mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits; legal values 8 to 64.
REQ-002 Parameter: CNT_W, default 6, iteration-counter width; it SHALL satisfy 2^CNT_W > WIDTH.
REQ-003 Port: clk, input, 1, single clock, rising-edge.
REQ-004 Port: rst, input, 1, reset; asynchronous, active-low.
REQ-005 Port: start, input, 1, request to begin an operation.
REQ-006 Port: func, input, 3, RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 Port: opA, input, WIDTH, rs1 operand (multiplicand/dividend).
REQ-008 Port: opB, input, WIDTH, rs2 operand (multiplier/divisor).
REQ-009 Port: abort, input, 1, cancels the in-flight operation.
REQ-010 Port: busy, output, 1, high while an operation is iterating.
REQ-011 Port: done, output, 1, one-cycle pulse when result becomes valid.
REQ-012 Port: out, output, WIDTH, result; held stable from the done cycle until the next accepted start.

Function
REQ-013 States SHALL be IDLE, BUSY and DONE; busy SHALL equal (state==BUSY), and done SHALL equal (state==DONE).
REQ-014 A start is accepted on a rising edge when start=1, abort=0 and the state is IDLE or DONE; func, opA and opB are latched on that edge.
REQ-015 start SHALL be ignored in BUSY; latched operands and func SHALL be unaffected.
REQ-016 Normal ops: BUSY for exactly WIDTH edges of radix-2 iteration (shift-add for multiply, restoring shift-subtract for divide), then DONE; done is high after edge WIDTH+1 counted from the accept edge.
REQ-017 Fast path: divisor==0, or DIV/REM with opA = most-negative and opB = all-ones, SHALL go directly from accept to DONE (done high after 1 edge).
REQ-018 DONE SHALL last exactly one cycle, then go to IDLE, unless a start is accepted in that cycle, in which case it goes to BUSY (or to DONE for the fast path).
REQ-019 MUL SHALL return the low WIDTH bits of the 2*WIDTH-bit product; MULH, MULHSU and MULHU SHALL return the high WIDTH bits, treating operands signed×signed, signed×unsigned and unsigned×unsigned respectively.
REQ-020 DIV/DIVU SHALL return the quotient rounded toward zero; REM/REMU SHALL return a remainder whose sign matches the dividend; signed ops iterate on magnitudes, then apply the sign correction.
REQ-021 On divide-by-zero, the quotient SHALL be all-ones and the remainder SHALL equal opA, for both signed and unsigned ops.
REQ-022 On signed overflow (most-negative ÷ -1), DIV SHALL return the most-negative value and REM SHALL return 0.
REQ-023 abort=1 in BUSY SHALL force IDLE on the next edge, with no done pulse; out SHALL keep its previous value.
REQ-024 abort=1 takes priority over a simultaneous start; in IDLE or DONE, abort alone SHALL have no effect other than suppressing acceptance.
REQ-025 Internal arithmetic SHALL use WIDTH+1 bits for division partial remainders and a 2*WIDTH-bit product register; no result bit SHALL depend on X or uninitialised state.

Reset
REQ-026 While rst=0, the state SHALL be IDLE and busy, done and out SHALL all be 0 (out = {WIDTH{1'b0}}), asynchronously.
REQ-027 Reset asserted mid-operation SHALL discard the operation; no done SHALL follow release.
REQ-028 The first start SHALL be accepted on the first rising edge after rst deasserts.

Verification (WIDTH=32)
REQ-029 MUL 7 × 0xFFFFFFFD -> out=0xFFFFFFEB, done exactly 33 edges after accept, busy high for 32 cycles.
REQ-030 MULH 0x80000000×0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF; MULHU same operands -> 0xFFFFFFFE.
REQ-031 DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM 0xFFFFFFF9/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFFE/2 -> 0x7FFFFFFF; REMU 7/3 -> 1.
REQ-032 DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM same -> 0; all four with done 1 edge after accept.
REQ-033 Abort at iteration 10 -> IDLE next edge, no done, out unchanged; start pulsed during BUSY -> ignored, original result delivered on schedule.
REQ-034 Back-to-back: new start during the done cycle -> accepted, busy next cycle; rst low at iteration 5 -> busy=0, done=0, out=0 immediately, no later done.

Source files
------------

// File: rtl/mul_div_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// The master issues operations; the slave reports busy/done and holds the result.
interface mul_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       func;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             abort;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;

  modport master (
    output start, func, opA, opB, abort,
    input  busy, done, out
  );

  modport slave (
    input  start, func, opA, opB, abort,
    output busy, done, out
  );
endinterface

// File: rtl/mul_div_unit.sv
// Radix-2 iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one result bit per cycle on operand magnitudes with a sign fix-up on the last cycle.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic      clk,
  input  logic      rst,
  mul_div_if.slave  bus
);

  localparam logic [WIDTH-1:0]        MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] ZERO_S   = '0;
  localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   out_q;

  logic [2:0]         func_q;
  logic               neg_hi;
  logic               neg_lo;
  logic [WIDTH-1:0]   mag_d;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     rem;

  logic signed [WIDTH-1:0] op_a_s, op_b_s;
  logic               is_div, a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               div_zero, div_ovf, fast;
  logic [WIDTH-1:0]   fast_res;
  logic               accept, last;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift, div_trial;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH:0]     rem_nxt;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   result;

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag, input logic neg);
    return neg ? (~mag + 1'b1) : mag;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign_wide(input logic [2*WIDTH-1:0] mag, input logic neg);
    return neg ? (~mag + 1'b1) : mag;
  endfunction

  assign op_a_s = bus.opA;
  assign op_b_s = bus.opB;
  assign accept = bus.start && !bus.abort && (state != BUSY);
  assign last   = (cnt == LAST_CNT);

  // Accept stage: operand magnitudes, signs and the single-cycle special cases
  always_comb begin
    is_div   = bus.func[2];
    a_signed = 1'b0;
    b_signed = 1'b0;
    if (is_div) begin
      a_signed = ~bus.func[0];
      b_signed = ~bus.func[0];
    end else begin
      a_signed = (bus.func[1:0] == 2'b01) || (bus.func[1:0] == 2'b10);
      b_signed = (bus.func[1:0] == 2'b01);
    end
    a_neg    = a_signed && (op_a_s < ZERO_S);
    b_neg    = b_signed && (op_b_s < ZERO_S);
    mag_a    = apply_sign(bus.opA, a_neg);
    mag_b    = apply_sign(bus.opB, b_neg);
    div_zero = is_div && (bus.opB == '0);
    div_ovf  = is_div && !bus.func[0] && (bus.opA == MOST_NEG) && (bus.opB == '1);
    fast     = div_zero || div_ovf;
    fast_res = '0;
    if (div_zero)
      fast_res = bus.func[1] ? bus.opA : '1;
    else if (div_ovf)
      fast_res = bus.func[1] ? '0 : MOST_NEG;
  end

  // Iteration stage: one multiply or divide step per BUSY cycle
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_d} : {(WIDTH+1){1'b0}});
    div_shift = {rem[WIDTH-1:0], acc[WIDTH-1]};
    div_trial = div_shift - {1'b0, mag_d};
    acc_nxt   = {mul_sum, acc[WIDTH-1:1]};
    rem_nxt   = rem;
    if (func_q[2]) begin
      if (!div_trial[WIDTH]) begin
        rem_nxt = div_trial;
        acc_nxt = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b1};
      end else begin
        rem_nxt = div_shift;
        acc_nxt = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Result stage: sign correction applied to the final iteration's values
  always_comb begin
    prod_fix = apply_sign_wide(acc_nxt, neg_hi);
    case (func_q)
      3'b000:          result = prod_fix[WIDTH-1:0];
      3'b100, 3'b101:  result = apply_sign(acc_nxt[WIDTH-1:0], neg_hi);
      3'b110, 3'b111:  result = apply_sign(rem_nxt[WIDTH-1:0], neg_lo);
      default:         result = prod_fix[2*WIDTH-1:WIDTH];
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      func_q <= bus.func;
      neg_hi <= a_neg ^ b_neg;
      neg_lo <= a_neg;
      mag_d  <= is_div ? mag_b : mag_a;
      acc    <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
      rem    <= '0;
    end else if (state == BUSY) begin
      acc    <= acc_nxt;
      rem    <= rem_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      out_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept)
        cnt <= '0;
      else if (state == BUSY)
        cnt <= cnt + CNT_W'(1);
      if (accept && fast)
        out_q <= fast_res;
      else if ((state == BUSY) && !bus.abort && last)
        out_q <= result;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept)
          state_nxt = fast ? DONE : BUSY;
        else
          state_nxt = IDLE;
      end
      BUSY: begin
        if (bus.abort)
          state_nxt = IDLE;
        else if (last)
          state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy = (state == BUSY);
  assign bus.done = (state == DONE);
  assign bus.out  = out_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit at WIDTH=32: results, latencies, abort, reset and handshake corners.
module tb_mul_div_unit;
  localparam int WIDTH = 32;

  logic        clk = 1'b0;
  logic        rst;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] last_out = '0;

  mul_div_if #(.WIDTH(WIDTH)) bus();

  mul_div_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
  endtask

  // Issue one op; latency counts the accept edge as 1. A nonzero poke pulses a
  // foreign start while the unit is busy.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input int poke);
    int lat;
    int nb;
    @(negedge clk);
    bus.start = 1'b1; bus.func = f; bus.opA = a; bus.opB = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    nb  = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) nb++;
      if (lat == poke) begin
        @(negedge clk);
        bus.start = 1'b1; bus.func = 3'b000; bus.opA = 32'd9; bus.opB = 32'd9;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_busy"}, 64'(nb), 64'(exp_lat - 1));
    check({tag, "_out"}, 64'(bus.out), 64'(exp));
    last_out = exp;
  endtask

  task automatic count_done(input string tag, input int cycles);
    int nd;
    nd = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) nd++;
    end
    check(tag, 64'(nd), 64'd0);
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.func = 3'b000;
    bus.opA = '0; bus.opB = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_out",  64'(bus.out),  64'd0);
    @(negedge clk);
    rst = 1'b1;

    run_op("mul",     3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 0);
    @(posedge clk); #1;
    check("done_pulse", 64'(bus.done), 64'd0);
    check("idle_busy",  64'(bus.busy), 64'd0);
    check("out_hold",   64'(bus.out),  64'hFFFFFFEB);

    run_op("mul_b0",  3'b000, 32'd5,        32'd0,        32'd0,        33, 0);
    run_op("mul_big", 3'b000, 32'h12345678, 32'h10,       32'h23456780, 33, 0);
    run_op("mulh",    3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, 0);
    run_op("mulh_n",  3'b001, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33, 0);
    run_op("mulhsu",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 0);
    run_op("mulhu",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 0);
    run_op("mulhu_s", 3'b011, 32'h12345678, 32'h10,       32'h1,        33, 0);

    run_op("div",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 0);
    run_op("rem",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 0);
    run_op("divu",    3'b101, 32'hFFFFFFFE, 32'd2,        32'h7FFFFFFF, 33, 0);
    run_op("remu",    3'b111, 32'd7,        32'd3,        32'd1,        33, 0);
    run_op("div_pn",  3'b100, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 33, 0);
    run_op("rem_pn",  3'b110, 32'd100,      32'hFFFFFFF9, 32'd2,        33, 0);
    run_op("div_nn",  3'b100, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       33, 0);
    run_op("rem_nn",  3'b110, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 33, 0);
    run_op("divu_mn", 3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0,        33, 0);
    run_op("remu_mn", 3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33, 0);

    run_op("div_z",   3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1, 0);
    run_op("rem_z",   3'b110, 32'd5,        32'd0,        32'd5,        1, 0);
    run_op("divu_z",  3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1, 0);
    run_op("remu_z",  3'b111, 32'd5,        32'd0,        32'd5,        1, 0);
    run_op("div_ov",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0);
    run_op("rem_ov",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1, 0);

    run_op("poke",    3'b101, 32'd100,      32'd7,        32'd14,       33, 5);

    // Abort during iteration 10
    @(negedge clk);
    bus.start = 1'b1; bus.func = 3'b000; bus.opA = 32'd3; bus.opB = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_out",  64'(bus.out),  64'(last_out));
    count_done("abort_quiet", 40);
    check("abort_out2", 64'(bus.out), 64'(last_out));

    // Abort wins over a simultaneous start
    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b1; bus.func = 3'b100; bus.opA = 32'd5; bus.opB = 32'd0;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.abort = 1'b0;
    check("prio_done", 64'(bus.done), 64'd0);
    check("prio_busy", 64'(bus.busy), 64'd0);

    run_op("b2b_a",   3'b011, 32'h10000,    32'h10000,    32'd1,        33, 0);
    run_op("b2b_b",   3'b000, 32'd6,        32'd7,        32'd42,       33, 0);
    run_op("b2b_c",   3'b100, 32'd9,        32'd0,        32'hFFFFFFFF, 1, 0);

    // Reset mid-operation
    @(negedge clk);
    bus.start = 1'b1; bus.func = 3'b000; bus.opA = 32'd3; bus.opB = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("rstmid_busy", 64'(bus.busy), 64'd0);
    check("rstmid_done", 64'(bus.done), 64'd0);
    check("rstmid_out",  64'(bus.out),  64'd0);
    @(negedge clk);
    rst = 1'b1;
    count_done("rstmid_quiet", 40);

    // First start accepted on the first edge after release
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b1; bus.func = 3'b101; bus.opA = 32'd9; bus.opB = 32'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("first_done", 64'(bus.done), 64'd1);
    check("first_out",  64'(bus.out),  64'hFFFFFFFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
